// File: rtl/conv_host_pkg.sv
// Shared types and constants for the convolution host: FSM encoding,
// result-memory select codes and bus widths.
package conv_host_pkg;
  localparam int DW = 20;
  localparam int AW = 12;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_e;
endpackage

// File: rtl/conv_host_if.sv
// Engine-facing bus of conv_host: image load, engine handshake, result
// memory ports and the layer-1 dump stream.
interface conv_host_if;
  import conv_host_pkg::*;

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_ready;
  logic          done;
  logic          err;

  modport master (
    output ld_valid, ld_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
           crd, caddr_rd, csel, rd_ready,
    input  ld_ready, ready, idata, cdata_rd, rd_valid, rd_data, rd_last,
           done, err
  );

  modport slave (
    input  ld_valid, ld_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
           crd, caddr_rd, csel, rd_ready,
    output ld_ready, ready, idata, cdata_rd, rd_valid, rd_data, rd_last,
           done, err
  );
endinterface

// File: rtl/conv_sp_ram.sv
// DEPTH x DW RAM: one synchronous write port, NRD asynchronous read ports.
// A same-cycle read of the written address returns the old word.
module conv_sp_ram
  import conv_host_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int NRD   = 1,
  localparam int RAW   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [RAW-1:0]           waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [NRD-1:0][RAW-1:0]  raddr_i,
  output logic [NRD-1:0][DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata_o[g] = mem_q[raddr_i[g]];
  end
endmodule

// File: rtl/conv_host.sv
// Convolution host: loads the input image, arms the engine, captures its
// layer results and streams layer 1 out once the engine finishes.
module conv_host
  import conv_host_pkg::*;
#(
  parameter int IMG_WORDS = 4096,
  parameter int L0_WORDS  = 4096,
  parameter int L1_WORDS  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  conv_host_if.slave bus
);
  localparam int IMG_AW = $clog2(IMG_WORDS);
  localparam int L0_AW  = $clog2(L0_WORDS);
  localparam int L1_AW  = $clog2(L1_WORDS);
  localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_WORDS - 1);
  localparam logic [L1_AW-1:0]  L1_LAST  = L1_AW'(L1_WORDS - 1);

  state_e              state_q, state_d;
  logic [IMG_AW-1:0]   ld_ptr_q, ld_ptr_d;
  logic [L1_AW-1:0]    dp_q, dp_d;
  logic                err_q, err_d;
  logic                busy_q;
  logic                img_we, l0_we, l1_we;
  logic [DW-1:0]       img_rd, l0_rd;
  logic [1:0][DW-1:0]  l1_rd;
  logic                unused_caddr;

  assign unused_caddr = ^bus.caddr_rd;

  assign img_we = (state_q == S_LOAD) && bus.ld_valid;
  assign l0_we  = (state_q == S_RUN) && bus.cwr && (bus.csel == CSEL_L0)
                  && (32'(bus.caddr_wr) < L0_WORDS);
  assign l1_we  = (state_q == S_RUN) && bus.cwr && (bus.csel == CSEL_L1)
                  && (32'(bus.caddr_wr) < L1_WORDS);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= S_IDLE;
      ld_ptr_q <= '0;
      dp_q     <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_ptr_q <= ld_ptr_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      busy_q   <= bus.busy;
    end

  always_comb begin
    state_d  = state_q;
    ld_ptr_d = ld_ptr_q;
    dp_d     = dp_q;
    err_d    = err_q;
    // Any write strobe that does not land in a result memory is a protocol error.
    if (bus.cwr && !(l0_we || l1_we)) err_d = 1'b1;
    unique case (state_q)
      S_IDLE: if (bus.ld_valid) state_d = S_LOAD;
      S_LOAD:
        if (bus.ld_valid) begin
          ld_ptr_d = ld_ptr_q + 1'b1;
          if (ld_ptr_q == IMG_LAST) begin
            ld_ptr_d = '0;
            state_d  = S_ARM;
          end
        end
      S_ARM:
        if (bus.busy)  state_d = S_RUN;
        else if (busy_q) err_d = 1'b1;
      S_RUN: if (!bus.busy) state_d = S_DUMP;
      S_DUMP:
        if (bus.rd_ready) begin
          dp_d = dp_q + 1'b1;
          if (dp_q == L1_LAST) begin
            dp_d    = '0;
            state_d = S_DONE;
          end
        end
      S_DONE: if (bus.ld_valid) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  conv_sp_ram #(.DEPTH(IMG_WORDS), .NRD(1)) u_img (
    .clk     (clk),
    .we_i    (img_we),
    .waddr_i (ld_ptr_q),
    .wdata_i (bus.ld_data),
    .raddr_i (bus.iaddr[IMG_AW-1:0]),
    .rdata_o (img_rd)
  );

  conv_sp_ram #(.DEPTH(L0_WORDS), .NRD(1)) u_l0 (
    .clk     (clk),
    .we_i    (l0_we),
    .waddr_i (bus.caddr_wr[L0_AW-1:0]),
    .wdata_i (bus.cdata_wr),
    .raddr_i (bus.caddr_rd[L0_AW-1:0]),
    .rdata_o (l0_rd)
  );

  // Port 0 serves the host read bus, port 1 the dump stream.
  conv_sp_ram #(.DEPTH(L1_WORDS), .NRD(2)) u_l1 (
    .clk     (clk),
    .we_i    (l1_we),
    .waddr_i (bus.caddr_wr[L1_AW-1:0]),
    .wdata_i (bus.cdata_wr),
    .raddr_i ({dp_q, bus.caddr_rd[L1_AW-1:0]}),
    .rdata_o (l1_rd)
  );

  assign bus.idata    = img_rd;
  assign bus.cdata_rd = !bus.crd                                    ? '0       :
                        (bus.csel == 3'b000 || bus.csel == CSEL_L0) ? l0_rd    :
                        (bus.csel == CSEL_L1)                       ? l1_rd[0] : '0;
  assign bus.ld_ready = (state_q == S_LOAD);
  assign bus.ready    = (state_q == S_ARM);
  assign bus.rd_valid = (state_q == S_DUMP);
  assign bus.rd_data  = l1_rd[1];
  assign bus.rd_last  = (state_q == S_DUMP) && (dp_q == L1_LAST);
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = err_q;
endmodule
